ppu_compositor: RTL and testbench
=================================

Name: ppu_compositor

Overview:
- Parametrised successor to the PPU top-level pixel multiplexer.
- Composites one background layer with LAYERS-1 sprite channels, resolves sprite-vs-background priority and left-edge clipping, then looks up an internal 32x6 palette RAM that mirrors its backdrop entries.
- Drives the final system palette index to ppu_vga through a 2-stage pipeline.
- Tracks the sprite-0 (primary) collision flag for ppu_ri; the palette RAM port is owned by ppu_ri.

Parameters:
- LAYERS, 3: total layers; layer 0 = background, 1..LAYERS-1 = sprite channels, lower index = higher priority; legal range 2..9.
- CLIP_W, 8: width in pixels of the left-edge clip region.
- PIPE_OUT, 1: 1 = register the output (2-cycle latency); 0 = 1-cycle latency.

Ports:
- clk_in  in  1  system clock (50 MHz)
- rst_in  in  1  reset; asynchronous, active-high
- pix_pulse_in  in  1  one-cycle strobe; the current pixel's inputs are valid
- nes_x_in  in  10  current pixel x
- nes_y_next_in  in  10  next scanline y
- bg_idx_in  in  4  background palette index {pal[1:0], col[1:0]}
- bg_clip_en_in  in  1  1 = force background transparent when x < CLIP_W
- spr_idx_in  in  4*(LAYERS-1)  sprite indices; channel k occupies [4k+3:4k]
- spr_behind_in  in  LAYERS-1  per channel: 1 = behind background
- spr_primary_in  in  LAYERS-1  per channel: 1 = pixel comes from OAM sprite 0
- spr_clip_en_in  in  1  1 = force sprites transparent when x < CLIP_W
- grey_in  in  1  greyscale mode
- pal_a_in  in  5  palette RAM address
- pal_d_in  in  6  palette RAM write data
- pal_wr_in  in  1  palette write strobe
- pal_rd_in  in  1  palette read strobe
- pal_d_out  out  6  palette read data
- pal_rd_valid_out  out  1  pal_d_out is valid
- sys_palette_idx_out  out  6  final system palette index
- sys_valid_out  out  1  sys_palette_idx_out updated this cycle
- pri_obj_col_out  out  1  sticky sprite-0 collision flag

Behaviour:
- Reset: every register and output is 0; palette RAM contents are not reset.
- Palette address map: eff(a) = (a[1:0]==0 && a[4]) ? {1'b0, a[3:0]} : a. So 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C for writes, reads and lookups.
- Palette write: on pal_wr_in, RAM[eff(pal_a_in)] <= pal_d_in.
- Palette read: on pal_rd_in, pal_d_out <= RAM[eff(pal_a_in)] one cycle later, with pal_rd_valid_out=1 for that one cycle.
  - Simultaneous read and write to the same effective address returns the new data (write-first).
  - pal_d_out holds its value between reads.
- Transparency: a layer is transparent when col==0, or when its clip enable is set and nes_x_in < CLIP_W.
- Stage 1, registered on pix_pulse_in:
  - Winner W = the lowest-index opaque sprite channel.
  - Select: sprite W if W exists and (!spr_behind[W] or bg transparent); else background if opaque; else backdrop.
  - Store the 5-bit lookup address: {1, spr_idx[W]}, {0, bg_idx} or 5'h00.
  - A behind-priority winning sprite still masks lower-priority sprites (NES priority quirk).
- Stage 2: look up RAM[eff(addr)] and AND the result with 6'h30 when grey_in=1 (grey_in sampled in stage 2).
  - PIPE_OUT=1: registered, sys_valid_out pulses 2 cycles after pix_pulse_in.
  - PIPE_OUT=0: combinational from the stage-1 register, 1-cycle latency.
  - The output holds between pulses.
  - A palette write landing between stage 1 and stage 2 is visible in that pixel's lookup.
- Collision flag:
  - Set on pix_pulse_in when any channel has spr_primary=1 and is opaque (unclipped), the background is opaque (unclipped), and nes_x_in != 255.
  - Priority bits are ignored for collision detection.
  - Cleared in any cycle where nes_y_next_in==0; clear wins over a simultaneous set.
  - Otherwise the flag holds.
- Back-to-back pix_pulse_in on consecutive cycles is supported at full throughput.
- Reset asserted mid-pipeline discards in-flight pixels; no sys_valid_out pulse follows reset deassertion.

Test Plan:
- Write 0x2A to palette address 0x10, then read address 0x00 -> pal_d_out=0x2A with pal_rd_valid_out high exactly 1 cycle after the read strobe; read 0x11 -> returns the 0x11 entry, not aliased.
- RAM[0x05]=0x16, RAM[0x15]=0x21; bg_idx=5, sprite0 idx=5 with spr_behind=0 -> output 0x21 two cycles after the pulse. Set spr_behind=1 -> 0x16. Set bg col=0 -> 0x21.
- LAYERS=3: ch0 idx=0x6 with behind=1, ch1 idx=0x9 in front, bg opaque -> background colour (ch0 masks ch1). ch0 idx=0x4 (transparent) -> RAM[0x19].
- x=3, bg_clip_en=1, sprite opaque, bg opaque -> sprite colour and no collision. Same stimulus at x=8 with a primary sprite -> pri_obj_col_out=1 the next cycle.
- Collision at x=255 -> flag stays 0. Raise the flag, then nes_y_next=0 in the same cycle as a new hit -> flag=0.
- grey_in=1 with RAM entry 0x27 -> output 0x20. Assert rst_in mid-pipeline -> all outputs 0 immediately, and no valid pulse afterwards.

Source files
------------

// File: rtl/ppu_compositor.sv
// ppu_compositor: composites one background layer with LAYERS-1 sprite channels.
// It resolves priority and left-edge clipping, looks up a 32x6 palette RAM and
// produces the system palette index with 1 or 2 cycles of latency (PIPE_OUT).
// Ports:
//   clk_in, rst_in                      clock, asynchronous active-high reset
//   pix_pulse_in                        per-pixel strobe that qualifies the pixel inputs
//   nes_x_in, nes_y_next_in             current x, next scanline y
//   bg_*/spr_*                          layer indices, priority, primary and clip controls
//   grey_in                             greyscale mask applied at lookup time
//   pal_a_in/pal_d_in/pal_wr_in/pal_rd_in  palette RAM port, owned by ppu_ri
//   pal_d_out, pal_rd_valid_out         registered palette read data and its valid
//   sys_palette_idx_out, sys_valid_out  final colour and its update strobe
//   pri_obj_col_out                     sticky sprite-0 collision flag
module ppu_compositor #(
  parameter int LAYERS   = 3,
  parameter int CLIP_W   = 8,
  parameter int PIPE_OUT = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    pix_pulse_in,
  input  logic [9:0]              nes_x_in,
  input  logic [9:0]              nes_y_next_in,
  input  logic [3:0]              bg_idx_in,
  input  logic                    bg_clip_en_in,
  input  logic [4*(LAYERS-1)-1:0] spr_idx_in,
  input  logic [LAYERS-2:0]       spr_behind_in,
  input  logic [LAYERS-2:0]       spr_primary_in,
  input  logic                    spr_clip_en_in,
  input  logic                    grey_in,
  input  logic [4:0]              pal_a_in,
  input  logic [5:0]              pal_d_in,
  input  logic                    pal_wr_in,
  input  logic                    pal_rd_in,
  output logic [5:0]              pal_d_out,
  output logic                    pal_rd_valid_out,
  output logic [5:0]              sys_palette_idx_out,
  output logic                    sys_valid_out,
  output logic                    pri_obj_col_out
);

  localparam int NSPR = LAYERS - 1;
  localparam logic [9:0] CLIP_X = 10'(CLIP_W);

  // Entries 0x10/0x14/0x18/0x1C are mirrors of the backdrop entries below them.
  function automatic logic [4:0] eff(input logic [4:0] a);
    return (a[1:0] == 2'b00 && a[4]) ? {1'b0, a[3:0]} : a;
  endfunction

  // ---------------- palette RAM (contents intentionally not reset) -----------
  logic [5:0] pal_ram [32];
  logic [4:0] port_a;
  assign port_a = eff(pal_a_in);

  always_ff @(posedge clk_in) begin
    if (pal_wr_in) pal_ram[port_a] <= pal_d_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pal_d_out        <= 6'h00;
      pal_rd_valid_out <= 1'b0;
    end else begin
      pal_rd_valid_out <= pal_rd_in;
      // Write-first: a same-cycle write to the read address returns the new data.
      if (pal_rd_in) pal_d_out <= pal_wr_in ? pal_d_in : pal_ram[port_a];
    end
  end

  // ---------------- layer transparency and priority --------------------------
  logic            in_clip;
  logic            bg_opaque;
  logic [NSPR-1:0] spr_opaque;
  assign in_clip   = (nes_x_in < CLIP_X);
  assign bg_opaque = (bg_idx_in[1:0] != 2'b00) && !(bg_clip_en_in && in_clip);

  always_comb begin
    for (int k = 0; k < NSPR; k++) begin
      spr_opaque[k] = (spr_idx_in[4*k +: 2] != 2'b00) && !(spr_clip_en_in && in_clip);
    end
  end

  logic       win_found;
  logic       win_behind;
  logic [3:0] win_idx;
  logic       pri_hit;
  logic [4:0] pix_addr;

  // Scan from the lowest priority upward so the lowest opaque index wins. A
  // behind-priority winner still masks every lower-priority channel.
  always_comb begin
    win_found  = 1'b0;
    win_behind = 1'b0;
    win_idx    = 4'h0;
    pri_hit    = 1'b0;
    for (int k = NSPR - 1; k >= 0; k--) begin
      if (spr_opaque[k]) begin
        win_found  = 1'b1;
        win_behind = spr_behind_in[k];
        win_idx    = spr_idx_in[4*k +: 4];
      end
      if (spr_opaque[k] && spr_primary_in[k]) pri_hit = 1'b1;
    end
    if (win_found && (!win_behind || !bg_opaque)) pix_addr = {1'b1, win_idx};
    else if (bg_opaque)                          pix_addr = {1'b0, bg_idx_in};
    else                                         pix_addr = 5'h00;
  end

  // ---------------- stage 1 and collision flag -------------------------------
  logic [4:0] s1_addr;
  logic       s1_vld;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_addr         <= 5'h00;
      s1_vld          <= 1'b0;
      pri_obj_col_out <= 1'b0;
    end else begin
      s1_vld <= pix_pulse_in;
      if (pix_pulse_in) s1_addr <= pix_addr;
      if (nes_y_next_in == 10'd0)
        pri_obj_col_out <= 1'b0;
      else if (pix_pulse_in && pri_hit && bg_opaque && nes_x_in != 10'd255)
        pri_obj_col_out <= 1'b1;
    end
  end

  // ---------------- stage 2 lookup -------------------------------------------
  logic [4:0] lk_a;
  logic [5:0] lk_raw;
  logic [5:0] lk_dat;
  logic [5:0] out_q;
  assign lk_a   = eff(s1_addr);
  // Bypass so a write landing in the lookup cycle is seen by this pixel.
  assign lk_raw = (pal_wr_in && port_a == lk_a) ? pal_d_in : pal_ram[lk_a];
  assign lk_dat = grey_in ? (lk_raw & 6'h30) : lk_raw;

  // Last delivered colour, so the output holds between pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      out_q <= 6'h00;
    else if (s1_vld) out_q <= lk_dat;
  end

  generate
    if (PIPE_OUT != 0) begin : g_reg_out
      logic vld_q;
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) vld_q <= 1'b0;
        else        vld_q <= s1_vld;
      end
      assign sys_palette_idx_out = out_q;
      assign sys_valid_out       = vld_q;
    end else begin : g_comb_out
      assign sys_palette_idx_out = s1_vld ? lk_dat : out_q;
      assign sys_valid_out       = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_ppu_compositor.sv
// Directed bench for ppu_compositor with default parameters (LAYERS=3,
// CLIP_W=8, PIPE_OUT=1); inputs change 1 time unit after the rising edge.
module tb_ppu_compositor;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       pix_pulse_in;
  logic [9:0] nes_x_in;
  logic [9:0] nes_y_next_in;
  logic [3:0] bg_idx_in;
  logic       bg_clip_en_in;
  logic [7:0] spr_idx_in;
  logic [1:0] spr_behind_in;
  logic [1:0] spr_primary_in;
  logic       spr_clip_en_in;
  logic       grey_in;
  logic [4:0] pal_a_in;
  logic [5:0] pal_d_in;
  logic       pal_wr_in;
  logic       pal_rd_in;
  logic [5:0] pal_d_out;
  logic       pal_rd_valid_out;
  logic [5:0] sys_palette_idx_out;
  logic       sys_valid_out;
  logic       pri_obj_col_out;

  int checks   = 0;
  int failures = 0;

  ppu_compositor #(.LAYERS(3), .CLIP_W(8), .PIPE_OUT(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pix_pulse_in(pix_pulse_in),
    .nes_x_in(nes_x_in), .nes_y_next_in(nes_y_next_in),
    .bg_idx_in(bg_idx_in), .bg_clip_en_in(bg_clip_en_in),
    .spr_idx_in(spr_idx_in), .spr_behind_in(spr_behind_in),
    .spr_primary_in(spr_primary_in), .spr_clip_en_in(spr_clip_en_in),
    .grey_in(grey_in), .pal_a_in(pal_a_in), .pal_d_in(pal_d_in),
    .pal_wr_in(pal_wr_in), .pal_rd_in(pal_rd_in), .pal_d_out(pal_d_out),
    .pal_rd_valid_out(pal_rd_valid_out),
    .sys_palette_idx_out(sys_palette_idx_out), .sys_valid_out(sys_valid_out),
    .pri_obj_col_out(pri_obj_col_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
    pal_a_in = a; pal_d_in = d; pal_wr_in = 1'b1;
    tick();
    pal_wr_in = 1'b0;
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [3:0] bg, input logic bgc,
                         input logic [7:0] spr, input logic [1:0] beh,
                         input logic [1:0] pri, input logic sc);
    nes_x_in = x; bg_idx_in = bg; bg_clip_en_in = bgc; spr_idx_in = spr;
    spr_behind_in = beh; spr_primary_in = pri; spr_clip_en_in = sc;
  endtask

  // Pulses one pixel and samples valid before, on and after the expected cycle.
  task automatic run_pixel(output logic [5:0] idx, output logic v_early,
                           output logic v_on, output logic v_late);
    pix_pulse_in = 1'b1;
    tick();
    v_early = sys_valid_out;
    pix_pulse_in = 1'b0;
    tick();
    v_on = sys_valid_out;
    idx  = sys_palette_idx_out;
    tick();
    v_late = sys_valid_out;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; pix_pulse_in = 1'b0; nes_y_next_in = 10'd5; grey_in = 1'b0;
    pal_a_in = 5'h00; pal_d_in = 6'h00; pal_wr_in = 1'b0; pal_rd_in = 1'b0;
    set_pix(10'd100, 4'h0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    tick(); tick();
    checks++;
    if ({pal_d_out, pal_rd_valid_out, sys_palette_idx_out, sys_valid_out, pri_obj_col_out} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h %b %h %b %b, want all 0", pal_d_out,
               pal_rd_valid_out, sys_palette_idx_out, sys_valid_out, pri_obj_col_out);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_palette();
    pal_write(5'h10, 6'h2A);
    pal_write(5'h11, 6'h33);
    pal_write(5'h01, 6'h07);
    pal_a_in = 5'h00; pal_rd_in = 1'b1;
    tick();
    pal_rd_in = 1'b0;
    checks++;
    if (pal_d_out !== 6'h2A || pal_rd_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL alias_read: got d=%h v=%b, want d=2a v=1", pal_d_out, pal_rd_valid_out);
    end
    tick();
    checks++;
    if (pal_d_out !== 6'h2A || pal_rd_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL read_hold: got d=%h v=%b, want d=2a v=0", pal_d_out, pal_rd_valid_out);
    end
    pal_a_in = 5'h11; pal_rd_in = 1'b1;
    tick();
    pal_rd_in = 1'b0;
    checks++;
    if (pal_d_out !== 6'h33) begin
      failures++;
      $display("FAIL no_alias_11: got %h, want 33", pal_d_out);
    end
    // 0x14 aliases 0x04: write and read in the same cycle returns new data.
    pal_a_in = 5'h14; pal_d_in = 6'h15; pal_wr_in = 1'b1; pal_rd_in = 1'b1;
    tick();
    pal_wr_in = 1'b0; pal_rd_in = 1'b0;
    checks++;
    if (pal_d_out !== 6'h15) begin
      failures++;
      $display("FAIL write_first: got %h, want 15", pal_d_out);
    end
    pal_a_in = 5'h04; pal_rd_in = 1'b1;
    tick();
    pal_rd_in = 1'b0;
    checks++;
    if (pal_d_out !== 6'h15) begin
      failures++;
      $display("FAIL alias_14_04: got %h, want 15", pal_d_out);
    end
  endtask

  task automatic test_priority();
    logic [5:0] idx; logic ve, vo, vl;
    pal_write(5'h05, 6'h16);
    pal_write(5'h15, 6'h21);
    set_pix(10'd100, 4'h5, 1'b0, 8'h05, 2'b00, 2'b00, 1'b0);
    run_pixel(idx, ve, vo, vl);
    checks++;
    if (idx !== 6'h21 || ve !== 1'b0 || vo !== 1'b1 || vl !== 1'b0) begin
      failures++;
      $display("FAIL sprite_front: got idx=%h valid=%b%b%b, want 21 valid=010", idx, ve, vo, vl);
    end
    checks++;
    if (sys_palette_idx_out !== 6'h21) begin
      failures++;
      $display("FAIL output_hold: got %h, want 21", sys_palette_idx_out);
    end
    spr_behind_in = 2'b01;
    run_pixel(idx, ve, vo, vl);
    checks++;
    if (idx !== 6'h16) begin
      failures++;
      $display("FAIL sprite_behind: got %h, want 16", idx);
    end
    bg_idx_in = 4'h4;
    run_pixel(idx, ve, vo, vl);
    checks++;
    if (idx !== 6'h21) begin
      failures++;
      $display("FAIL behind_bg_transparent: got %h, want 21", idx);
    end
  endtask

  task automatic test_mask();
    logic [5:0] idx; logic ve, vo, vl;
    pal_write(5'h19, 6'h2C);
    set_pix(10'd100, 4'h5, 1'b0, 8'h96, 2'b01, 2'b00, 1'b0);
    run_pixel(idx, ve, vo, vl);
    checks++;
    if (idx !== 6'h16) begin
      failures++;
      $display("FAIL behind_masks_lower: got %h, want 16", idx);
    end
    spr_idx_in = 8'h94;
    run_pixel(idx, ve, vo, vl);
    checks++;
    if (idx !== 6'h2C) begin
      failures++;
      $display("FAIL ch1_wins: got %h, want 2c", idx);
    end
    set_pix(10'd100, 4'h8, 1'b0, 8'hC0, 2'b00, 2'b00, 1'b0);
    run_pixel(idx, ve, vo, vl);
    checks++;
    if (idx !== 6'h2A) begin
      failures++;
      $display("FAIL backdrop: got %h, want 2a", idx);
    end
  endtask

  task automatic test_clip_collision();
    logic [5:0] idx; logic ve, vo, vl;
    set_pix(10'd3, 4'h5, 1'b1, 8'h05, 2'b00, 2'b01, 1'b0);
    run_pixel(idx, ve, vo, vl);
    checks++;
    if (idx !== 6'h21 || pri_obj_col_out !== 1'b0) begin
      failures++;
      $display("FAIL bg_clip: got idx=%h col=%b, want 21 col=0", idx, pri_obj_col_out);
    end
    set_pix(10'd3, 4'h5, 1'b0, 8'h05, 2'b00, 2'b01, 1'b1);
    run_pixel(idx, ve, vo, vl);
    checks++;
    if (idx !== 6'h16 || pri_obj_col_out !== 1'b0) begin
      failures++;
      $display("FAIL spr_clip: got idx=%h col=%b, want 16 col=0", idx, pri_obj_col_out);
    end
    set_pix(10'd8, 4'h5, 1'b1, 8'h05, 2'b00, 2'b01, 1'b0);
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0;
    checks++;
    if (pri_obj_col_out !== 1'b1) begin
      failures++;
      $display("FAIL col_at_clip_edge: got %b, want 1", pri_obj_col_out);
    end
    tick(); tick();
  endtask

  task automatic test_collision_edges();
    nes_y_next_in = 10'd0;
    tick();
    nes_y_next_in = 10'd5;
    checks++;
    if (pri_obj_col_out !== 1'b0) begin
      failures++;
      $display("FAIL col_clear: got %b, want 0", pri_obj_col_out);
    end
    set_pix(10'd255, 4'h5, 1'b0, 8'h50, 2'b10, 2'b10, 1'b0);
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0;
    checks++;
    if (pri_obj_col_out !== 1'b0) begin
      failures++;
      $display("FAIL col_x255: got %b, want 0", pri_obj_col_out);
    end
    // Channel 1 is behind and masked by nothing; priority must not matter.
    nes_x_in = 10'd10;
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0;
    tick(); tick();
    checks++;
    if (pri_obj_col_out !== 1'b1) begin
      failures++;
      $display("FAIL col_behind_sticky: got %b, want 1", pri_obj_col_out);
    end
    nes_y_next_in = 10'd0; pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0; nes_y_next_in = 10'd5;
    checks++;
    if (pri_obj_col_out !== 1'b0) begin
      failures++;
      $display("FAIL col_clear_wins: got %b, want 0", pri_obj_col_out);
    end
    tick(); tick();
  endtask

  task automatic test_grey();
    logic [5:0] idx; logic ve, vo, vl;
    pal_write(5'h07, 6'h27);
    set_pix(10'd50, 4'h7, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    grey_in = 1'b1;
    run_pixel(idx, ve, vo, vl);
    grey_in = 1'b0;
    checks++;
    if (idx !== 6'h20) begin
      failures++;
      $display("FAIL grey: got %h, want 20", idx);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] a_idx, b_idx; logic v0, v1, v2, v3;
    set_pix(10'd60, 4'h5, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    pix_pulse_in = 1'b1;
    tick();
    v0 = sys_valid_out;
    bg_idx_in = 4'h7;
    tick();
    pix_pulse_in = 1'b0;
    v1 = sys_valid_out; a_idx = sys_palette_idx_out;
    tick();
    v2 = sys_valid_out; b_idx = sys_palette_idx_out;
    tick();
    v3 = sys_valid_out;
    checks++;
    if (a_idx !== 6'h16 || b_idx !== 6'h27 || {v0, v1, v2, v3} !== 4'b0110) begin
      failures++;
      $display("FAIL back_to_back: got %h %h valid=%b%b%b%b, want 16 27 valid=0110",
               a_idx, b_idx, v0, v1, v2, v3);
    end
  endtask

  task automatic test_late_write();
    pal_write(5'h06, 6'h05);
    set_pix(10'd70, 4'h6, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0;
    pal_write(5'h06, 6'h11);
    checks++;
    if (sys_palette_idx_out !== 6'h11 || sys_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL late_write: got %h v=%b, want 11 v=1", sys_palette_idx_out, sys_valid_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    // Raise the flag and leave read data nonzero so the reset has work to do.
    set_pix(10'd20, 4'h5, 1'b0, 8'h05, 2'b00, 2'b01, 1'b0);
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0;
    rst_in = 1'b1;
    #1;
    checks++;
    if ({pal_d_out, pal_rd_valid_out, sys_palette_idx_out, sys_valid_out, pri_obj_col_out} !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid: got %h %b %h %b %b, want all 0", pal_d_out,
               pal_rd_valid_out, sys_palette_idx_out, sys_valid_out, pri_obj_col_out);
    end
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sys_valid_out !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL no_valid_after_reset: got %0d pulses, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_palette();
    test_priority();
    test_mask();
    test_clip_collision();
    test_collision_edges();
    test_grey();
    test_back_to_back();
    test_late_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
